// File: rtl/counter_gate_ctrl_if.sv
// Handshake and counter-side bundle between the gate controller and its neighbours.
// master = controller view; slave = counter/consumer/stimulus view.
interface counter_gate_ctrl_if;
  logic        start;
  logic        event_in;
  logic        cnt_enable;
  logic        cnt_clear_overflow;
  logic [31:0] cnt_count;
  logic        cnt_overflow;
  logic        busy;
  logic [31:0] result;
  logic        result_wrapped;
  logic        result_valid;
  logic        result_ready;

  modport master (
    input  start, event_in, cnt_count, cnt_overflow, result_ready,
    output cnt_enable, cnt_clear_overflow, busy, result, result_wrapped, result_valid
  );

  modport slave (
    output start, event_in, cnt_count, cnt_overflow, result_ready,
    input  cnt_enable, cnt_clear_overflow, busy, result, result_wrapped, result_valid
  );
endinterface

// File: rtl/counter_gate_ctrl.sv
// Opens a GATE_CYCLES-long counting window on a free-running event counter and reports
// the number of events seen in it as a start/end snapshot difference.
module counter_gate_ctrl #(
  parameter logic [31:0] GATE_CYCLES = 32'd1000,
  parameter bit          CONTINUOUS  = 1'b0
) (
  input logic                 clk_in,
  input logic                 reset,
  counter_gate_ctrl_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARM    = 3'd1;
  localparam logic [2:0] S_GATE   = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_RESULT = 3'd4;

  generate
    if (GATE_CYCLES == 32'd0) begin : g_bad_gate_cycles
      $error("counter_gate_ctrl: GATE_CYCLES must be >= 1");
    end
  endgenerate

  logic [2:0]  r_state;
  logic [31:0] r_gate_cnt;
  logic [31:0] r_count_start;
  logic [31:0] r_result;
  logic        r_wrapped;
  logic        r_valid;
  logic        w_gate_open;
  logic        w_gate_last;

  assign w_gate_open = (r_state == S_GATE);
  assign w_gate_last = (r_gate_cnt == GATE_CYCLES - 32'd1);

  // Qualified by reset so the counter's own reset branch (taken only when enable=0) wins.
  assign bus.cnt_enable         = bus.event_in & w_gate_open & reset;
  assign bus.cnt_clear_overflow = (r_state == S_ARM) & reset;
  assign bus.busy               = (r_state != S_IDLE);
  assign bus.result             = r_result;
  assign bus.result_wrapped     = r_wrapped;
  assign bus.result_valid       = r_valid;

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_gate_cnt    <= 32'd0;
      r_count_start <= 32'd0;
      r_result      <= 32'd0;
      r_wrapped     <= 1'b0;
      r_valid       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state <= S_ARM;
          end
        end
        S_ARM: begin
          r_count_start <= bus.cnt_count;
          r_gate_cnt    <= 32'd0;
          r_state       <= S_GATE;
        end
        S_GATE: begin
          if (w_gate_last) begin
            r_state <= S_SETTLE;
          end else begin
            r_gate_cnt <= r_gate_cnt + 32'd1;
          end
        end
        S_SETTLE: begin
          // Modular difference stays exact across a counter wrap (N < 2^32, <=1 event/cycle).
          r_result  <= bus.cnt_count - r_count_start;
          r_wrapped <= bus.cnt_overflow;
          r_valid   <= 1'b1;
          r_state   <= S_RESULT;
        end
        S_RESULT: begin
          if (bus.result_ready) begin
            r_valid <= 1'b0;
            r_state <= CONTINUOUS ? S_ARM : S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
